// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcodes, immediate-format selects and bubble encoding
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_ISH = 3'b101;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

endpackage

// File: rtl/imm_sel_dec.sv
// rtl/imm_sel_dec.sv - combinational immediate-format select from a raw instruction word
module imm_sel_dec
  import rv_pkg::*;
(
  input  logic [31:0] ins,
  output logic [2:0]  imm_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = ins[6:0];
  assign funct3      = ins[14:12];
  assign unused_bits = ^{ins[31:15], ins[11:7]};

  always_comb begin
    imm_sel = IMM_I;
    case (opcode)
      // Shift-immediates carry a 5-bit shamt, not a sign-extended imm12.
      OP_IMM:           imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_ISH : IMM_I;
      OP_LOAD, OP_JALR,
      OP_SYSTEM:        imm_sel = IMM_I;
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_JAL:           imm_sel = IMM_J;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      default:          imm_sel = IMM_I;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register, instruction fetch and IF/ID pipeline register
module if_id_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = rv_pkg::NOP_INS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_ins,
  output logic [2:0]  id_imm_sel
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [2:0]  id_imm_sel_q, id_imm_sel_d;
  logic [2:0]  dec_imm_sel;
  logic        unused_redirect_lsb;

  assign pc_plus4            = pc_q + 32'd4;
  assign imem_addr           = pc_q;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  imm_sel_dec u_imm_sel_dec (
    .ins     (imem_rdata),
    .imm_sel (dec_imm_sel)
  );

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // imem_rdata only reaches the register on a capture cycle, so X from idle memory never leaks.
  always_comb begin
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_ins_d     = id_ins_q;
    id_imm_sel_d = id_imm_sel_q;
    if (redirect_valid || flush) begin
      id_valid_d   = 1'b0;
      id_ins_d     = NOP_INS;
      id_imm_sel_d = IMM_I;
    end else if (!stall) begin
      id_valid_d   = 1'b1;
      id_pc_d      = pc_q;
      id_pc4_d     = pc_plus4;
      id_ins_d     = imem_rdata;
      id_imm_sel_d = dec_imm_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_pc4_q     <= 32'd0;
      id_ins_q     <= NOP_INS;
      id_imm_sel_q <= IMM_I;
    end else begin
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_ins_q     <= id_ins_d;
      id_imm_sel_q <= id_imm_sel_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_pc4     = id_pc4_q;
  assign id_ins     = id_ins_q;
  assign id_imm_sel = id_imm_sel_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] imem_addr, id_pc, id_pc4, id_ins;
  logic        id_valid;
  logic [2:0]  id_imm_sel;

  logic        b_zero = 1'b0;
  logic [31:0] b_zero32 = 32'd0;
  logic [31:0] b_rdata = 32'h0000_0013;
  logic [31:0] b_imem_addr, b_id_pc, b_id_pc4, b_id_ins;
  logic        b_id_valid;
  logic [2:0]  b_id_imm_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_ins(id_ins), .id_imm_sel(id_imm_sel)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(b_zero), .flush(b_zero),
    .redirect_valid(b_zero), .redirect_pc(b_zero32),
    .imem_addr(b_imem_addr), .imem_rdata(b_rdata),
    .id_valid(b_id_valid), .id_pc(b_id_pc), .id_pc4(b_id_pc4),
    .id_ins(b_id_ins), .id_imm_sel(b_id_imm_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [2:0] sel);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_pc4"}, id_pc4, pc + 32'd4);
    chk({tag, "_ins"}, id_ins, ins);
    chk({tag, "_sel"}, {29'd0, id_imm_sel}, {29'd0, sel});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_rdata = 32'h0000_0013;
    step();
    step();
    rst = 1'b0;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ins", id_ins, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_sel", {29'd0, id_imm_sel}, 32'd0);
    chk("wrap_addr0", b_imem_addr, 32'hFFFF_FFFC);

    imem_rdata = 32'h0020_9463;
    step();
    chk_id("bne", 1'b1, 32'h0, 32'h0020_9463, 3'b010);
    chk("bne_addr", imem_addr, 32'h4);
    chk("wrap_addr1", b_imem_addr, 32'h0);
    chk("wrap_pc", b_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", b_id_pc4, 32'h0);

    imem_rdata = 32'h0030_9093;
    step();
    chk_id("slli", 1'b1, 32'h4, 32'h0030_9093, 3'b101);
    imem_rdata = 32'h0000_00B7;
    step();
    chk_id("lui", 1'b1, 32'h8, 32'h0000_00B7, 3'b100);
    imem_rdata = 32'hFE11_2E23;
    step();
    chk_id("sw", 1'b1, 32'hC, 32'hFE11_2E23, 3'b001);
    chk("sw_addr", imem_addr, 32'h10);

    stall = 1'b1; imem_rdata = 32'h0000_006F;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h10);
      chk_id("stall", 1'b1, 32'hC, 32'hFE11_2E23, 3'b001);
    end
    stall = 1'b0;
    step();
    chk_id("jal", 1'b1, 32'h10, 32'h0000_006F, 3'b011);
    chk("jal_addr", imem_addr, 32'h14);

    imem_rdata = 32'h0000_0033;
    step();
    chk_id("add", 1'b1, 32'h14, 32'h0000_0033, 3'b000);

    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; stall = 1'b1;
    imem_rdata = 32'h0030_9093;
    step();
    chk("redir_addr", imem_addr, 32'h200);
    chk_id("redir_bubble", 1'b0, 32'h14, 32'h0000_0013, 3'b000);
    redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'h0020_9463;
    step();
    chk_id("redir_tgt", 1'b1, 32'h200, 32'h0020_9463, 3'b010);
    chk("redir_next", imem_addr, 32'h204);

    flush = 1'b1;
    step();
    chk("flush_addr", imem_addr, 32'h208);
    chk_id("flush", 1'b0, 32'h200, 32'h0000_0013, 3'b000);
    stall = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    chk("flstall_addr", imem_addr, 32'h208);
    chk_id("flstall", 1'b0, 32'h200, 32'h0000_0013, 3'b000);
    flush = 1'b0; stall = 1'b0;
    step();
    chk_id("after_fl", 1'b1, 32'h208, 32'h0000_006F, 3'b011);

    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_ins", id_ins, 32'h0000_0013);
    chk("mrst_pc", id_pc, 32'h0);
    chk("mrst_pc4", id_pc4, 32'h0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
